// File: rtl/sort_sequencer_pkg.sv
// Shared definitions for the sort sequencer and the register file it drives.
// Holds the FSM state encoding, default geometry and the derived width helpers.
package sort_sequencer_pkg;

  localparam int unsigned DefNumRegs = 8;
  localparam int unsigned DefDataW   = 4;

  typedef enum logic [1:0] {StIdle, StInit, StCmp, StDone} state_e;

  function automatic int unsigned addr_w(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Wide enough for the worst case of one swap per comparison in every pass.
  function automatic int unsigned cnt_w(input int unsigned num_regs);
    return $clog2(num_regs * (num_regs - 1) / 2 + 1);
  endfunction

  localparam int unsigned DefAddrW = addr_w(DefNumRegs);

endpackage

// File: rtl/sort_sequencer_if.sv
// Command/status bundle between the sort sequencer and its register file.
// The sequencer is the slave side; the register-file owner is the master.
interface sort_sequencer_if
  import sort_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned DATA_W   = DefDataW
) ();

  localparam int unsigned AW = addr_w(NUM_REGS);
  localparam int unsigned CW = cnt_w(NUM_REGS);

  logic              start;
  logic              skip_init;
  logic [DATA_W-1:0] r_in [NUM_REGS];
  logic              init;
  logic [AW-1:0]     x;
  logic [AW-1:0]     y;
  logic              swap;
  logic              busy;
  logic              done;
  logic [CW-1:0]     swap_cnt;

  modport slave (
    input  start, skip_init, r_in,
    output init, x, y, swap, busy, done, swap_cnt
  );

  modport master (
    output start, skip_init, r_in,
    input  init, x, y, swap, busy, done, swap_cnt
  );

endinterface

// File: rtl/sort_sequencer_pair_compare.sv
// Decides whether two adjacent registers are in the wrong order for the sort direction.
// Equal operands are never reported out of order, so the sort is stable.
module sort_sequencer_pair_compare
  import sort_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter bit          DESCENDING = 1'b1
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              out_of_order_o
);

  assign out_of_order_o = DESCENDING ? (a_i < b_i) : (a_i > b_i);

endmodule

// File: rtl/sort_sequencer.sv
// Bubble-sort sequencer: walks adjacent register pairs, issuing swaps to an external
// register file, and stops early once a whole pass completes without a swap.
module sort_sequencer
  import sort_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS   = DefNumRegs,
  parameter int unsigned DATA_W     = DefDataW,
  parameter bit          DESCENDING = 1'b1
) (
  input logic             clk,
  input logic             reset,
  sort_sequencer_if.slave bus
);

  localparam int unsigned AW = addr_w(NUM_REGS);
  localparam int unsigned CW = cnt_w(NUM_REGS);
  localparam logic [AW-1:0] LastIdx = AW'(NUM_REGS - 2);

  state_e        state_q, state_d;
  logic [AW-1:0] pass_q, pass_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;

  logic [AW-1:0]     idx_p1;
  logic [DATA_W-1:0] op_a, op_b;
  logic              out_of_order;
  logic              end_of_pass;
  logic              swapped_in_pass;

  assign idx_p1          = idx_q + AW'(1);
  assign op_a            = bus.r_in[idx_q];
  assign op_b            = bus.r_in[idx_p1];
  assign end_of_pass     = idx_q >= (LastIdx - pass_q);
  assign swapped_in_pass = flag_q | out_of_order;

  sort_sequencer_pair_compare #(
    .DATA_W    (DATA_W),
    .DESCENDING(DESCENDING)
  ) u_pair_compare (
    .a_i           (op_a),
    .b_i           (op_b),
    .out_of_order_o(out_of_order)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pass_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_d   = '0;
          pass_d  = '0;
          idx_d   = '0;
          flag_d  = 1'b0;
          state_d = bus.skip_init ? StCmp : StInit;
        end
      end
      StInit: begin
        pass_d  = '0;
        idx_d   = '0;
        flag_d  = 1'b0;
        state_d = StCmp;
      end
      StCmp: begin
        if (out_of_order) cnt_d = cnt_q + CW'(1);
        if (!end_of_pass) begin
          idx_d  = idx_p1;
          flag_d = swapped_in_pass;
        end else if (!swapped_in_pass || (pass_q == LastIdx)) begin
          state_d = StDone;
        end else begin
          pass_d = pass_q + AW'(1);
          idx_d  = '0;
          flag_d = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.init     = (state_q == StInit);
    bus.busy     = (state_q == StInit) || (state_q == StCmp);
    bus.swap     = (state_q == StCmp) && out_of_order;
    bus.done     = (state_q == StDone);
    bus.x        = (state_q == StCmp) ? idx_q : '0;
    bus.y        = (state_q == StCmp) ? idx_p1 : '0;
    bus.swap_cnt = cnt_q;
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Self-checking bench: two sequencers (descending and ascending) each driving a bench
// register file, compared cycle by cycle against a plain bubble-sort reference.
module tb_sort_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic skip = 1'b0;
  logic asc = 1'b0;
  logic load_now = 1'b0;

  logic [3:0] init_vals [8];
  logic [3:0] rf_d [8];
  logic [3:0] rf_a [8];
  logic [3:0] o_rf [8];

  int total = 0;
  int bad = 0;

  logic [2:0] exp_x [$];
  logic       exp_sw [$];
  int         exp_cnt;
  logic [3:0] exp_fin [8];

  always #5 clk = ~clk;

  sort_sequencer_if #(.NUM_REGS(8), .DATA_W(4)) bus_d ();
  sort_sequencer_if #(.NUM_REGS(8), .DATA_W(4)) bus_a ();

  sort_sequencer #(.NUM_REGS(8), .DATA_W(4), .DESCENDING(1'b1)) dut_d (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_d.slave)
  );

  sort_sequencer #(.NUM_REGS(8), .DATA_W(4), .DESCENDING(1'b0)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a.slave)
  );

  assign bus_d.start     = start & ~asc;
  assign bus_a.start     = start & asc;
  assign bus_d.skip_init = skip;
  assign bus_a.skip_init = skip;
  assign bus_d.r_in      = rf_d;
  assign bus_a.r_in      = rf_a;

  always @(posedge clk) begin
    if (bus_d.init || load_now) rf_d <= init_vals;
    else if (bus_d.swap) begin
      rf_d[bus_d.x] <= rf_d[bus_d.y];
      rf_d[bus_d.y] <= rf_d[bus_d.x];
    end
  end

  always @(posedge clk) begin
    if (bus_a.init || load_now) rf_a <= init_vals;
    else if (bus_a.swap) begin
      rf_a[bus_a.x] <= rf_a[bus_a.y];
      rf_a[bus_a.y] <= rf_a[bus_a.x];
    end
  end

  logic       o_init, o_busy, o_swap, o_done;
  logic [2:0] o_x, o_y;
  logic [4:0] o_cnt;

  always_comb begin
    o_init = asc ? bus_a.init : bus_d.init;
    o_busy = asc ? bus_a.busy : bus_d.busy;
    o_swap = asc ? bus_a.swap : bus_d.swap;
    o_done = asc ? bus_a.done : bus_d.done;
    o_x    = asc ? bus_a.x : bus_d.x;
    o_y    = asc ? bus_a.y : bus_d.y;
    o_cnt  = asc ? bus_a.swap_cnt : bus_d.swap_cnt;
    for (int i = 0; i < 8; i++) o_rf[i] = asc ? rf_a[i] : rf_d[i];
  end

  // Reference: textbook bubble sort with early exit, recording every comparison.
  task automatic model();
    logic [3:0] m [8];
    logic [3:0] t;
    logic sw, any;
    exp_x.delete();
    exp_sw.delete();
    exp_cnt = 0;
    m = init_vals;
    for (int p = 0; p < 7; p++) begin
      any = 1'b0;
      for (int i = 0; i < 7 - p; i++) begin
        sw = asc ? (m[i] > m[i+1]) : (m[i] < m[i+1]);
        exp_x.push_back(3'(i));
        exp_sw.push_back(sw);
        if (sw) begin
          t = m[i]; m[i] = m[i+1]; m[i+1] = t;
          exp_cnt++;
          any = 1'b1;
        end
      end
      if (!any) break;
    end
    exp_fin = m;
  endtask

  // Starts a sort at the current negedge and checks every cycle until the idle cycle.
  task automatic run_sort(input bit use_skip, input bit hold);
    logic [31:0] got, want;
    logic [9:0]  ov, ev;
    model();
    if (use_skip) begin
      load_now = 1'b1;
      @(negedge clk);
      load_now = 1'b0;
    end
    start = 1'b1;
    skip  = use_skip;
    @(negedge clk);
    if (!hold) start = 1'b0;
    if (!use_skip) begin
      total++;
      if ({o_init, o_busy, o_swap, o_done} !== 4'b1100)
        $display("FAIL init_cycle: got %b want 1100", {o_init, o_busy, o_swap, o_done});
      if ({o_init, o_busy, o_swap, o_done} !== 4'b1100) bad++;
      @(negedge clk);
    end
    for (int j = 0; j < exp_x.size(); j++) begin
      ov = {o_init, o_busy, o_swap, o_done, o_x, o_y};
      ev = {1'b0, 1'b1, exp_sw[j], 1'b0, exp_x[j], exp_x[j] + 3'd1};
      total++;
      if (ov !== ev) begin
        bad++;
        $display("FAIL cmp_step %0d: got %b want %b", j, ov, ev);
      end
      @(negedge clk);
    end
    total++;
    if ({o_init, o_busy, o_swap, o_done, o_x, o_y, o_cnt} !== {4'b0001, 6'd0, 5'(exp_cnt)}) begin
      bad++;
      $display("FAIL done_cycle: got init/busy/swap/done=%b x=%0d y=%0d cnt=%0d want 0001 0 0 %0d",
               {o_init, o_busy, o_swap, o_done}, o_x, o_y, o_cnt, exp_cnt);
    end
    @(negedge clk);
    total++;
    if ({o_init, o_busy, o_swap, o_done, o_x, o_y, o_cnt} !== {4'b0000, 6'd0, 5'(exp_cnt)}) begin
      bad++;
      $display("FAIL idle_after_done: got flags=%b x=%0d y=%0d cnt=%0d want 0000 0 0 %0d",
               {o_init, o_busy, o_swap, o_done}, o_x, o_y, o_cnt, exp_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      got[i*4 +: 4]  = o_rf[i];
      want[i*4 +: 4] = exp_fin[i];
    end
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL final_rf: got %h want %h", got, want);
    end
  endtask

  task automatic set_vals(input int kind);
    for (int i = 0; i < 8; i++) begin
      case (kind)
        0:       init_vals[i] = 4'(i);
        1:       init_vals[i] = 4'h3;
        default: init_vals[i] = 4'($urandom_range(0, 15));
      endcase
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({bus_d.init, bus_d.busy, bus_d.swap, bus_d.done, bus_d.x, bus_d.y, bus_d.swap_cnt} !== 15'd0) begin
      bad++;
      $display("FAIL reset_desc: got %b want 0", {bus_d.init, bus_d.busy, bus_d.swap, bus_d.done});
    end
    total++;
    if ({bus_a.init, bus_a.busy, bus_a.swap, bus_a.done, bus_a.x, bus_a.y, bus_a.swap_cnt} !== 15'd0) begin
      bad++;
      $display("FAIL reset_asc: got %b want 0", {bus_a.init, bus_a.busy, bus_a.swap, bus_a.done});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_reverse();
    asc = 1'b0;
    set_vals(0);
    run_sort(1'b0, 1'b0);
    total++;
    if (o_cnt !== 5'd28) begin
      bad++;
      $display("FAIL reverse_cnt: got %0d want 28", o_cnt);
    end
    total++;
    if ({o_rf[0], o_rf[1], o_rf[2], o_rf[7]} !== 16'h7650) begin
      bad++;
      $display("FAIL reverse_order: got %h want 7650", {o_rf[0], o_rf[1], o_rf[2], o_rf[7]});
    end
  endtask

  task automatic test_ascending_sorted();
    asc = 1'b1;
    set_vals(0);
    run_sort(1'b0, 1'b0);
    total++;
    if (o_cnt !== 5'd0) begin
      bad++;
      $display("FAIL asc_cnt: got %0d want 0", o_cnt);
    end
  endtask

  task automatic test_equal_skip();
    asc = 1'b0;
    set_vals(1);
    run_sort(1'b1, 1'b0);
  endtask

  task automatic test_outlier_skip();
    asc = 1'b0;
    set_vals(0);
    init_vals[3] = 4'd9;
    run_sort(1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      asc = 1'($urandom_range(0, 1));
      set_vals(2);
      run_sort(1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_sort();
    asc = 1'b0;
    set_vals(0);
    start = 1'b1;
    skip  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({o_init, o_busy, o_swap, o_done, o_x, o_y, o_cnt} !== 15'd0) begin
      bad++;
      $display("FAIL reset_mid_sort: got flags=%b x=%0d y=%0d cnt=%0d want all 0",
               {o_init, o_busy, o_swap, o_done}, o_x, o_y, o_cnt);
    end
    @(negedge clk);
    run_sort(1'b0, 1'b0);
  endtask

  task automatic test_start_held();
    asc = 1'b0;
    set_vals(0);
    run_sort(1'b0, 1'b1);
    set_vals(2);
    run_sort(1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) init_vals[i] = '0;
    test_reset();
    test_full_reverse();
    test_ascending_sorted();
    test_equal_skip();
    test_outlier_skip();
    test_random();
    test_reset_mid_sort();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
